// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO on clk, decodes frames addressed to
// PHY_ADDRESS and serves reads/writes from a 32 x 16 register file (regs 2/3 hold the PHY ID).
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDRESS   = 5'h0c,
  parameter logic [31:0] PHY_ID        = 32'h0141_0DD0,
  parameter int          PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_BITS);

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP
  } state_t;

  state_t      state, state_nx;
  logic        mdc_s1, mdc_s2, mdc_prev;
  logic        mdio_s1, mdio_s2;
  logic        rise;
  logic [5:0]  pre_cnt, pre_nx;
  logic [4:0]  bit_cnt, bit_nx;
  logic        op_first, op_first_nx;
  logic        is_read, is_read_nx;
  logic [9:0]  addr_sh, addr_nx;
  logic [9:0]  addr_full;
  logic [15:0] shadow, shadow_nx;
  logic [15:0] data_sh, data_nx;
  logic        mdio_o_nx, mdio_t_nx;
  logic        wr_fire;
  logic [15:0] regs [32];
  logic [15:0] rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_s1  <= 1'b0;
      mdio_s2  <= 1'b0;
    end else begin
      mdc_s1   <= mdc;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= mdio_i;
      mdio_s2  <= mdio_s1;
    end
  end

  assign rise = mdc_s2 & ~mdc_prev;

  // {PHYAD, REGAD} including the bit being sampled on this edge
  assign addr_full = {addr_sh[8:0], mdio_s2};

  always_comb begin
    rd_val = regs[addr_full[4:0]];
    if (addr_full[4:0] == 5'd2) rd_val = PHY_ID[31:16];
    if (addr_full[4:0] == 5'd3) rd_val = PHY_ID[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pre_cnt  <= 6'd0;
      bit_cnt  <= 5'd0;
      op_first <= 1'b0;
      is_read  <= 1'b0;
      addr_sh  <= 10'd0;
      shadow   <= 16'd0;
      data_sh  <= 16'd0;
      mdio_o   <= 1'b0;
      mdio_t   <= 1'b1;
    end else begin
      state    <= state_nx;
      pre_cnt  <= pre_nx;
      bit_cnt  <= bit_nx;
      op_first <= op_first_nx;
      is_read  <= is_read_nx;
      addr_sh  <= addr_nx;
      shadow   <= shadow_nx;
      data_sh  <= data_nx;
      mdio_o   <= mdio_o_nx;
      mdio_t   <= mdio_t_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pre_nx      = pre_cnt;
    bit_nx      = bit_cnt;
    op_first_nx = op_first;
    is_read_nx  = is_read;
    addr_nx     = addr_sh;
    shadow_nx   = shadow;
    data_nx     = data_sh;
    mdio_o_nx   = mdio_o;
    mdio_t_nx   = mdio_t;
    wr_fire     = 1'b0;
    if (rise) begin
      bit_nx = bit_cnt + 5'd1;
      unique case (state)
        IDLE: begin
          if (mdio_s2) begin
            if (pre_cnt < PRE_MAX) pre_nx = pre_cnt + 6'd1;
          end else if (pre_cnt >= PRE_MAX) begin
            // counter cleared here so every later return to IDLE starts a fresh preamble
            state_nx = ST;
            pre_nx   = 6'd0;
          end else begin
            pre_nx = 6'd0;
          end
        end
        ST: begin
          bit_nx = 5'd0;
          if (mdio_s2) state_nx = OP;
          else         state_nx = IDLE;
        end
        OP: begin
          if (bit_cnt == 5'd0) begin
            op_first_nx = mdio_s2;
          end else if (op_first != mdio_s2) begin
            is_read_nx = op_first;
            state_nx   = PHYAD;
            bit_nx     = 5'd0;
          end else begin
            state_nx = IDLE;
          end
        end
        PHYAD: begin
          addr_nx = addr_full;
          if (bit_cnt == 5'd4) begin
            state_nx = REGAD;
            bit_nx   = 5'd0;
          end
        end
        REGAD: begin
          addr_nx = addr_full;
          if (bit_cnt == 5'd4) begin
            bit_nx = 5'd0;
            if (addr_full[9:5] != PHY_ADDRESS) begin
              state_nx = SKIP;
            end else begin
              state_nx  = TA;
              shadow_nx = rd_val;
            end
          end
        end
        TA: begin
          if (bit_cnt == 5'd0) begin
            if (is_read) begin
              mdio_t_nx = 1'b0;
              mdio_o_nx = 1'b0;
            end
          end else begin
            bit_nx = 5'd0;
            if (is_read) begin
              mdio_o_nx = shadow[15];
              shadow_nx = {shadow[14:0], 1'b0};
              state_nx  = RD_DATA;
            end else begin
              state_nx = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (bit_cnt == 5'd15) begin
            mdio_t_nx = 1'b1;
            mdio_o_nx = 1'b0;
            state_nx  = IDLE;
          end else begin
            mdio_o_nx = shadow[15];
            shadow_nx = {shadow[14:0], 1'b0};
          end
        end
        WR_DATA: begin
          data_nx = {data_sh[14:0], mdio_s2};
          if (bit_cnt == 5'd15) begin
            wr_fire  = 1'b1;
            state_nx = IDLE;
          end
        end
        SKIP: begin
          if (bit_cnt == 5'd17) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 16'd0;
    end else begin
      wr_valid <= wr_fire;
      if (wr_fire) begin
        wr_addr <= addr_sh[4:0];
        wr_data <= data_nx;
      end
    end
  end

  // Regs 2/3 are never written; reads of them are served from PHY_ID instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
    end else if (wr_fire && addr_sh[4:0] != 5'd2 && addr_sh[4:0] != 5'd3) begin
      regs[addr_sh[4:0]] <= data_nx;
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: an MDIO master model drives frames at 4/4 clk MDC
// phases; expected read/write results go through scoreboard queues.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        m_drv;
  logic        m_val;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        line;
  logic        samp;

  int n_vec = 0;
  int n_err = 0;
  int drive_cnt = 0;
  int wr_cnt = 0;
  int wr_long = 0;
  logic        wr_prev = 1'b0;
  logic [4:0]  cap_addr = 5'd0;
  logic [15:0] cap_data = 16'd0;

  logic [16:0] exp_rd [$];
  logic [20:0] exp_wr [$];

  always #5 clk = ~clk;

  // Pulled-up bus: released line reads 1
  assign line   = mdio_t ? 1'b1 : mdio_o;
  assign mdio_i = m_drv ? m_val : line;

  mdio_phy_responder dut (
    .clk      (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk) begin
    if (!mdio_t) drive_cnt <= drive_cnt + 1;
    if (wr_valid && !wr_prev) begin
      wr_cnt   <= wr_cnt + 1;
      cap_addr <= wr_addr;
      cap_data <= wr_data;
    end
    if (wr_valid && wr_prev) wr_long <= wr_long + 1;
    wr_prev <= wr_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MDC period: 4 clk low then 4 clk high; line sampled just before the rise
  task automatic mbit(input logic drv, input logic v);
    @(negedge clk);
    m_drv = drv;
    m_val = v;
    mdc   = 1'b0;
    repeat (3) @(negedge clk);
    samp = line;
    @(negedge clk);
    mdc = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra);
    logic [15:0] h;
    h = {2'b01, op, phy, ra, 2'b00};
    for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1);
    for (int i = 15; i >= 2; i--) mbit(1'b1, h[i]);
  endtask

  // Returns {TA second bit, 16 data bits} as seen on the bus
  task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                         output logic [16:0] obs);
    logic [17:0] b;
    send_hdr(pre, 2'b10, phy, ra);
    for (int i = 17; i >= 0; i--) begin
      mbit(1'b0, 1'b0);
      b[i] = samp;
    end
    obs = b[16:0];
  endtask

  task automatic do_write(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] d);
    send_hdr(32, op, phy, ra);
    mbit(1'b1, 1'b1);
    mbit(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) mbit(1'b1, d[i]);
    @(negedge clk);
    m_drv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_check(input string tag, input logic [4:0] ra, input logic [15:0] d);
    int w0;
    w0 = wr_cnt;
    exp_wr.push_back({ra, d});
    do_write(2'b01, 5'h0c, ra, d);
    check({tag, "_pulses"}, wr_cnt - w0, 1);
    check({tag, "_addr_data"}, {cap_addr, cap_data}, exp_wr.pop_front());
  endtask

  task automatic read_check(input string tag, input int pre, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [16:0] exp);
    logic [16:0] obs;
    exp_rd.push_back(exp);
    do_read(pre, phy, ra, obs);
    check(tag, obs, exp_rd.pop_front());
  endtask

  initial begin
    int d0;
    int w0;
    reset = 1'b1;
    mdc   = 1'b0;
    m_drv = 1'b0;
    m_val = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mdio_t", mdio_t, 1);
    check("rst_mdio_o", mdio_o, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    read_check("rd_id_hi", 32, 5'h0c, 5'd2, {1'b0, 16'h0141});
    read_check("rd_id_lo", 32, 5'h0c, 5'd3, {1'b0, 16'h0DD0});
    repeat (2) @(negedge clk);
    check("released_after_rd", mdio_t, 1);

    write_check("wr_r5", 5'd5, 16'hA5C3);
    read_check("rd_r5", 32, 5'h0c, 5'd5, {1'b0, 16'hA5C3});
    write_check("wr_r2", 5'd2, 16'hFFFF);
    read_check("rd_r2_ro", 32, 5'h0c, 5'd2, {1'b0, 16'h0141});

    d0 = drive_cnt;
    read_check("rd_phy_mismatch", 32, 5'h0d, 5'd3, 17'h1FFFF);
    check("mismatch_no_drive", drive_cnt - d0, 0);
    read_check("rd_after_mismatch", 32, 5'h0c, 5'd3, {1'b0, 16'h0DD0});

    d0 = drive_cnt;
    read_check("rd_short_pre", 31, 5'h0c, 5'd2, 17'h1FFFF);
    check("short_pre_no_drive", drive_cnt - d0, 0);
    d0 = drive_cnt;
    w0 = wr_cnt;
    do_write(2'b11, 5'h0c, 5'd6, 16'h1234);
    check("bad_op_no_drive", drive_cnt - d0, 0);
    check("bad_op_no_wr", wr_cnt - w0, 0);
    read_check("rd_after_bad_op", 32, 5'h0c, 5'd5, {1'b0, 16'hA5C3});

    send_hdr(32, 2'b10, 5'h0c, 5'd5);
    for (int i = 0; i < 10; i++) mbit(1'b0, 1'b0);
    check("driving_before_rst", mdio_t, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_rd_release", mdio_t, 1);
    check("rst_mid_rd_mdio_o", mdio_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d0 = drive_cnt;
    for (int i = 0; i < 8; i++) mbit(1'b0, 1'b0);
    check("rst_no_further_drive", drive_cnt - d0, 0);
    read_check("rd_r5_after_rst", 32, 5'h0c, 5'd5, {1'b0, 16'h0000});

    write_check("b2b_wr_r7", 5'd7, 16'h3C5A);
    read_check("b2b_rd_r7", 32, 5'h0c, 5'd7, {1'b0, 16'h3C5A});

    check("wr_valid_single_clk", wr_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
